// File: rtl/decomp_sched.sv
// decomp_sched: round-robin job scheduler in front of the HACD page decompressor.
// Owns the level start/done handshake, per-requester completion and a hang watchdog.
module decomp_sched #(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*14-1:0]   req_comp_size,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      cmpl_valid,
    output logic                    cmpl_err,
    output logic                    decomp_start,
    output logic [13:0]             comp_size,
    input  logic                    decomp_done,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles,
    output logic                    busy,
    output logic                    fault
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_CMPL,
        S_FAULT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_start;
    logic [13:0]          r_comp_size;
    logic [NUM_REQ-1:0]   r_cmpl_valid;
    logic                 r_cmpl_err;
    logic                 r_busy;
    logic                 r_fault;

    logic                 w_found;
    logic [PTR_W-1:0]     w_winner;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_expired;
    logic                 w_accept;

    assign decomp_start = r_start;
    assign comp_size    = r_comp_size;
    assign cmpl_valid   = r_cmpl_valid;
    assign cmpl_err     = r_cmpl_err;
    assign busy         = r_busy;
    assign fault        = r_fault;

    // Round-robin search starting just after the last winner, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_accept = !rst_i && (r_state == S_IDLE) && w_found;

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_expired = (timeout_cycles != '0) &&
                       (r_wdog == (timeout_cycles - TIMEOUT_W'(1)));

    // Next-state logic; done wins over watchdog expiry in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (decomp_done) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_expired) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_RELEASE: begin
                if (!decomp_done) begin
                    w_state_nxt = S_CMPL;
                end else if (w_expired) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_CMPL: begin
                w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the job context latched at acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_comp_size <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner     <= w_winner;
                r_rr_ptr    <= w_winner;
                r_comp_size <= req_comp_size[14*w_winner +: 14];
            end
        end
    end

    // Watchdog counts RUN and RELEASE cycles; restarts when done is seen in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if (r_state == S_RUN && decomp_done) begin
            r_wdog <= '0;
        end else if (r_state == S_RUN || r_state == S_RELEASE) begin
            r_wdog <= r_wdog + TIMEOUT_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_cmpl_valid <= '0;
            r_cmpl_err   <= 1'b0;
        end else begin
            r_start      <= (w_state_nxt == S_RUN);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_fault      <= r_fault || (w_state_nxt == S_FAULT);
            r_cmpl_valid <= '0;
            r_cmpl_err   <= 1'b0;
            if (w_state_nxt == S_CMPL) begin
                r_cmpl_valid <= NUM_REQ'(1) << r_owner;
            end else if (w_state_nxt == S_FAULT && r_state != S_FAULT) begin
                r_cmpl_valid <= NUM_REQ'(1) << r_owner;
                r_cmpl_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decomp_sched.sv
// tb_decomp_sched: randomized scoreboard bench for decomp_sched.
// Requester and decompressor models feed an expected-job queue checked by a monitor.
module tb_decomp_sched;
    localparam int NUM_REQ = 2;
    localparam int TW      = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*14-1:0] req_comp_size = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    cmpl_valid;
    logic                  cmpl_err;
    logic                  decomp_start;
    logic [13:0]           comp_size;
    logic                  decomp_done = 1'b0;
    logic [TW-1:0]         timeout_cycles = 16'd200;
    logic                  busy;
    logic                  fault;

    decomp_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_W(TW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid      (req_valid),
        .req_comp_size  (req_comp_size),
        .req_ready      (req_ready),
        .cmpl_valid     (cmpl_valid),
        .cmpl_err       (cmpl_err),
        .decomp_start   (decomp_start),
        .comp_size      (comp_size),
        .decomp_done    (decomp_done),
        .timeout_cycles (timeout_cycles),
        .busy           (busy),
        .fault          (fault)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        int          who;
        logic [13:0] size;
        logic        err;
    } exp_t;

    exp_t               q[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 m_ptr = NUM_REQ - 1;
    int                 g_grants = 0;
    int                 g_last = -1;
    bit                 g_gen = 1'b0;
    int                 g_jobs_left = 0;
    bit                 g_hang = 1'b0;
    int                 g_lat = 20;
    bit                 g_lat_rand = 1'b0;
    int                 g_stale = 0;
    bit                 g_stale_rand = 1'b0;
    logic [NUM_REQ-1:0] pend_raise = '0;
    logic [13:0]        pend_size [NUM_REQ];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic raise(input int who, input logic [13:0] sz);
        pend_size[who]  = sz;
        pend_raise[who] = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int c;
        c = 0;
        while (c < bound && !(q.size() == 0 && !busy && req_valid == '0 &&
               pend_raise == '0 && g_jobs_left == 0)) begin
            @(negedge clk_i);
            c++;
        end
        if (c >= bound) expire(nm);
    endtask

    task automatic wait_grants(input string nm, input int n, input int bound);
        int c;
        c = 0;
        while (c < bound && g_grants < n) begin
            @(negedge clk_i);
            c++;
        end
        if (g_grants < n) expire(nm);
    endtask

    // Requesters plus round-robin reference: predicts each grant and queues the job.
    initial begin : requesters
        logic [NUM_REQ-1:0] acc;
        int w;
        int j;
        exp_t e;
        forever begin
            @(negedge clk_i);
            acc = '0;
            if (!rst_i && req_ready != '0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
                chk("grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
                if (w >= 0) begin
                    e.who  = w;
                    e.size = req_comp_size[w*14 +: 14];
                    e.err  = g_hang;
                    q.push_back(e);
                    m_ptr  = w;
                    g_last = w;
                    g_grants++;
                    acc[w] = 1'b1;
                end
            end
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (pend_raise[i]) begin
                    req_valid[i] = 1'b1;
                    req_comp_size[i*14 +: 14] = pend_size[i];
                    pend_raise[i] = 1'b0;
                end else if (g_gen && g_jobs_left > 0 && !req_valid[i] &&
                             $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_comp_size[i*14 +: 14] = 14'($urandom);
                    g_jobs_left--;
                end
            end
        end
    end

    // Decompressor model: done after a latency, held stale after start falls.
    initial begin : decomp_model
        bit on;
        int hi;
        int lat;
        int rel;
        logic nxt;
        on  = 1'b0;
        hi  = 0;
        lat = 0;
        rel = 0;
        forever begin
            @(negedge clk_i);
            nxt = decomp_done;
            if (rst_i) begin
                on  = 1'b0;
                hi  = 0;
                rel = 0;
                nxt = 1'b0;
            end else if (decomp_start) begin
                if (!on) begin
                    chk("start_while_done_high", 32'(decomp_done), 32'd0);
                    on  = 1'b1;
                    hi  = 0;
                    lat = g_lat_rand ? int'($urandom_range(1, 40)) : g_lat;
                end
                hi++;
                if (!g_hang && hi == lat) nxt = 1'b1;
            end else if (on) begin
                chk("start_high_cycles", 32'(hi),
                    g_hang ? 32'(timeout_cycles) : 32'(lat + 1));
                on  = 1'b0;
                rel = g_stale_rand ? int'($urandom_range(0, 3)) : g_stale;
                if (rel == 0) nxt = 1'b0;
            end else if (rel > 0) begin
                rel--;
                if (rel == 0) nxt = 1'b0;
            end
            @(posedge clk_i);
            #1;
            decomp_done = nxt;
        end
    end

    // Monitor: checks latched size at start and pops the queue on each completion.
    initial begin : monitor
        logic prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_start = 1'b0;
            end else begin
                if (decomp_start && !prev_start) begin
                    if (q.size() == 0) begin
                        expire("unexpected_start");
                    end else begin
                        chk("comp_size", 32'(comp_size), 32'(q[0].size));
                    end
                end
                prev_start = decomp_start;
                if (cmpl_valid != '0) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_cmpl: got %0h required none",
                                 cmpl_valid);
                    end else begin
                        e = q.pop_front();
                        chk("cmpl_owner", 32'(cmpl_valid), 32'd1 << e.who);
                        chk("cmpl_err", 32'(cmpl_err), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin : main
        int first;
        int base;
        int c;
        int blocked;
        for (int i = 0; i < NUM_REQ; i++) pend_size[i] = '0;

        raise(0, 14'h0123);
        repeat (3) @(negedge clk_i);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cmpl_valid", 32'(cmpl_valid), 32'd0);
        chk("rst_cmpl_err", 32'(cmpl_err), 32'd0);
        chk("rst_start", 32'(decomp_start), 32'd0);
        chk("rst_comp_size", 32'(comp_size), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;

        wait_idle("single_job", 300);
        chk("single_busy_after", 32'(busy), 32'd0);
        chk("single_fault", 32'(fault), 32'd0);

        base = g_grants;
        raise(0, 14'($urandom));
        raise(1, 14'($urandom));
        wait_grants("rr_first", base + 1, 300);
        first = g_last;
        raise(first, 14'($urandom));
        wait_grants("rr_second", base + 2, 300);
        chk("rr_second_other", 32'(g_last), 32'(1 - first));
        wait_grants("rr_third", base + 3, 300);
        chk("rr_third_back", 32'(g_last), 32'(first));
        wait_idle("rr_idle", 500);

        g_stale = 3;
        raise(1, 14'h2a5c);
        wait_idle("stale_done", 300);
        g_stale = 0;

        g_lat_rand   = 1'b1;
        g_stale_rand = 1'b1;
        g_jobs_left  = 40;
        g_gen        = 1'b1;
        wait_idle("random_jobs", 10000);
        g_gen        = 1'b0;
        g_lat_rand   = 1'b0;
        g_stale_rand = 1'b0;

        g_lat = 20;
        raise(0, 14'h1111);
        raise(1, 14'h2222);
        c = 0;
        while (!decomp_start && c < 100) begin
            @(negedge clk_i);
            c++;
        end
        if (!decomp_start) expire("midrun_start");
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b1;
        q.delete();
        m_ptr = NUM_REQ - 1;
        #1;
        chk("midrun_async_start", 32'(decomp_start), 32'd0);
        chk("midrun_async_busy", 32'(busy), 32'd0);
        chk("midrun_no_cmpl", 32'(cmpl_valid), 32'd0);
        raise(0, 14'h0abc);
        raise(1, 14'h0def);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        base = g_grants;
        wait_grants("post_reset_grant", base + 1, 100);
        chk("post_reset_winner", 32'(g_last), 32'd0);
        wait_idle("post_reset_idle", 500);

        timeout_cycles = '0;
        g_lat = 70000;
        raise(1, 14'h3fff);
        wait_idle("wdog_off", 72000);
        chk("wdog_off_fault", 32'(fault), 32'd0);
        g_lat = 20;
        timeout_cycles = 16'd200;

        timeout_cycles = 16'd50;
        g_hang = 1'b1;
        raise(0, 14'h0555);
        c = 0;
        while (!fault && c < 300) begin
            @(negedge clk_i);
            c++;
        end
        if (!fault) expire("timeout_fault");
        repeat (3) @(negedge clk_i);
        chk("timeout_start_low", 32'(decomp_start), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd1);
        raise(1, 14'h0777);
        blocked = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (req_ready != '0) blocked++;
        end
        chk("fault_no_grant", 32'(blocked), 32'd0);
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_cmpl_drained", 32'(q.size()), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        q.delete();
        m_ptr = NUM_REQ - 1;
        g_hang = 1'b0;
        timeout_cycles = 16'd200;
        #1;
        chk("fault_cleared", 32'(fault), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        wait_idle("after_fault", 500);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_fault", 32'(fault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
